matrix_stream_transposer: RTL and testbench



---
 rtl/matrix_pkg.sv | 19 +
 rtl/mtx_idx_counter.sv | 44 ++++
 rtl/matrix_stream_transposer.sv | 123 ++++++++++++
 tb/tb_matrix_stream_transposer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and defaults for the streaming matrix transposer.
// Holds the FSM state enum, the default dimensions and the index-width helper.
package matrix_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } mtx_xpose_state_t;

    localparam int MTX_N     = 3;
    localparam int MTX_D     = 4;
    localparam int MTX_WIDTH = 8;

    // Width of an index counting 0..range-1, never narrower than one bit.
    function automatic int idx_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/mtx_idx_counter.sv
// Two-level row/column wrap counter: col counts 0..COLS-1 and carries into row 0..ROWS-1.
// clr has priority over inc; last flags the final (ROWS-1, COLS-1) position.
module mtx_idx_counter
    import matrix_pkg::*;
#(
    parameter int  ROWS = 3,
    parameter int  COLS = 4,
    localparam int RW   = idx_width(ROWS),
    localparam int CW   = idx_width(COLS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic row_end;
    logic col_end;

    assign row_end = (row == RW'(ROWS - 1));
    assign col_end = (col == CW'(COLS - 1));
    assign last    = row_end && col_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_stream_transposer.sv
// Buffers an N x D row-major element stream and replays it as the D x N transpose.
// Optional MTX_ROW_LAST_EN adds out_row_last marking the last element of each output row.
module matrix_stream_transposer
    import matrix_pkg::*;
#(
    parameter int N     = MTX_N,
    parameter int D     = MTX_D,
    parameter int WIDTH = MTX_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             done
`ifdef MTX_ROW_LAST_EN
    ,
    output logic             out_row_last
`endif
);

    localparam int NW = idx_width(N);
    localparam int DW = idx_width(D);

    mtx_xpose_state_t state;

    logic [WIDTH-1:0] mem [N][D];

    logic [NW-1:0] wr_r;
    logic [DW-1:0] wr_c;
    logic          wr_last;
    logic [DW-1:0] rd_r;
    logic [NW-1:0] rd_c;
    logic          rd_last;

    logic wr_inc;
    logic rd_inc;

    // A flush in the same cycle as a handshake swallows that handshake.
    assign wr_inc = in_valid && in_ready && !flush;
    assign rd_inc = out_valid && out_ready && !flush;

    mtx_idx_counter #(
        .ROWS (N),
        .COLS (D)
    ) u_wr_idx (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_inc),
        .clr   (flush),
        .row   (wr_r),
        .col   (wr_c),
        .last  (wr_last)
    );

    mtx_idx_counter #(
        .ROWS (D),
        .COLS (N)
    ) u_rd_idx (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_inc),
        .clr   (flush),
        .row   (rd_r),
        .col   (rd_c),
        .last  (rd_last)
    );

    always_ff @(posedge clk) begin
        if (wr_inc) begin
            mem[wr_r][wr_c] <= in_data;
        end
    end

    assign out_data = mem[rd_c][rd_r];

`ifdef MTX_ROW_LAST_EN
    assign out_row_last = out_valid && (rd_c == NW'(N - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else if (flush) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                FILL: begin
                    if (wr_inc && wr_last) begin
                        state     <= DRAIN;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (rd_inc && rd_last) begin
                        state     <= FILL;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state     <= FILL;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_transposer.sv
// Self-checking bench for matrix_stream_transposer (N=3, D=4, WIDTH=8).
// Expected transpose order is queued when a matrix is driven and popped on each output handshake.
module tb_matrix_stream_transposer;
    import matrix_pkg::*;

    localparam int N  = 3;
    localparam int D  = 4;
    localparam int NE = N * D;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       flush     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       done;
`ifdef MTX_ROW_LAST_EN
    logic       out_row_last;
`endif

    matrix_stream_transposer #(.N(N), .D(D), .WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .done         (done)
`ifdef MTX_ROW_LAST_EN
        ,
        .out_row_last (out_row_last)
`endif
    );

    always #5 clk = ~clk;

    typedef logic [7:0] mat_t [NE];

    typedef struct {
        int base;
        int gap_pct;
        int stall_pct;
    } vec_t;

    typedef struct {
        int         r;
        int         c;
        logic [7:0] v;
        int         oidx;
    } spot_t;

    int         checks   = 0;
    int         errors   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         hs_cnt   = 0;
    logic       done_exp = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    int         done_cnt = 0;
    int         n_mtx    = 0;
    logic [7:0] ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            hs_cnt     = 0;
            done_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("done", {31'd0, done}, {31'd0, done_exp});
            if (done) begin
                done_cnt++;
                check("ready_on_done", {30'd0, in_ready, out_valid}, 32'd2);
            end
            done_exp = 1'b0;
            if (prev_stall && out_valid) check("hold", {24'd0, out_data}, {24'd0, prev_data});
`ifdef MTX_ROW_LAST_EN
            check("row_last", {31'd0, out_row_last},
                  {31'd0, out_valid && ((hs_cnt % N) == N - 1)});
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected none", out_data);
                end else begin
                    ev = exp_q.pop_front();
                    check("data", {24'd0, out_data}, {24'd0, ev});
                end
                got_q.push_back(out_data);
                hs_cnt++;
                if (hs_cnt == NE) begin
                    hs_cnt   = 0;
                    done_exp = 1'b1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic make_seq(input int base, output mat_t m);
        for (int i = 0; i < NE; i++) m[i] = 8'(base + i + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end
    endtask

    task automatic fill_matrix(input mat_t m, input int gap_pct);
        int acc;
        int cyc;
        for (int r = 0; r < D; r++)
            for (int c = 0; c < N; c++) exp_q.push_back(m[c * D + r]);
        acc = 0;
        cyc = 0;
        while (acc < NE && cyc < 2000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(99) >= gap_pct);
            in_data   = in_valid ? m[acc] : 8'($urandom);
            out_ready = $urandom_range(1);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            cyc++;
        end
        if (acc < NE) begin
            checks++;
            errors++;
            $display("FAIL fill_timeout: accepted %0d, expected %0d", acc, NE);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("latency", {30'd0, in_ready, out_valid}, 32'd1);
    endtask

    // Returns with the final handshake pending on the next rising edge.
    task automatic drain(input int stall_pct, output int cyc);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 2000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(99) >= stall_pct);
            in_valid  = $urandom_range(1);
            in_data   = 8'($urandom);
            @(negedge clk); #1;
            cyc++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic drain_n(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = 1'b0;
            @(negedge clk); #1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic bench_clear();
        exp_q.delete();
        hs_cnt   = 0;
        done_exp = 1'b0;
    endtask

    initial begin
        vec_t  vecs[4];
        spot_t spots[4];
        mat_t  m;
        int    cyc;
        int    nflush[2];

        vecs[0] = '{base: 0,   gap_pct: 0,  stall_pct: 0};
        vecs[1] = '{base: 0,   gap_pct: 50, stall_pct: 50};
        vecs[2] = '{base: 100, gap_pct: 0,  stall_pct: 0};
        vecs[3] = '{base: 200, gap_pct: 30, stall_pct: 70};

        spots[0] = '{r: 0, c: 0, v: 8'h80, oidx: 0};
        spots[1] = '{r: 2, c: 3, v: 8'h7f, oidx: 11};
        spots[2] = '{r: 1, c: 2, v: 8'hff, oidx: 7};
        spots[3] = '{r: 0, c: 3, v: 8'h00, oidx: 9};

        nflush[0] = 5;
        nflush[1] = NE - 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {29'd0, in_ready, out_valid, done}, 32'd4);
        @(posedge clk); #1;
        reset = 1'b1;

        // Table-driven streams; entries 1->2 also run back-to-back.
        for (int t = 0; t < 4; t++) begin
            make_seq(vecs[t].base, m);
            fill_matrix(m, vecs[t].gap_pct);
            drain(vecs[t].stall_pct, cyc);
            n_mtx++;
            if (vecs[t].stall_pct == 0) check("drain_cycles", cyc, NE);
        end
        idle(1);

        // Extreme values land at their transposed positions.
        for (int i = 0; i < NE; i++) m[i] = 8'(10 + i);
        foreach (spots[s]) m[spots[s].r * D + spots[s].c] = spots[s].v;
        got_q.delete();
        fill_matrix(m, 0);
        drain(0, cyc);
        n_mtx++;
        idle(1);
        foreach (spots[s]) check("spot", {24'd0, got_q[spots[s].oidx]}, {24'd0, spots[s].v});

        // Flush in FILL, coincident with one more input handshake.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < nflush[f]; i++) begin
                @(posedge clk); #1;
                in_valid = 1'b1;
                in_data  = 8'(50 + i);
            end
            @(posedge clk); #1;
            flush    = 1'b1;
            in_valid = 1'b1;
            in_data  = 8'h63;
            @(posedge clk); #1;
            flush    = 1'b0;
            in_valid = 1'b0;
            @(negedge clk);
            check("flush_fill_state", {30'd0, in_ready, out_valid}, 32'd2);
            make_seq(0, m);
            fill_matrix(m, 0);
            drain(0, cyc);
            n_mtx++;
            check("flush_drain_cycles", cyc, NE);
            idle(1);
        end

        // Flush during DRAIN after 3 outputs.
        make_seq(20, m);
        fill_matrix(m, 0);
        drain_n(3);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bench_clear();
        @(negedge clk);
        check("flush_drain_state", {29'd0, in_ready, out_valid, done}, 32'd4);
        make_seq(0, m);
        fill_matrix(m, 0);
        drain(0, cyc);
        n_mtx++;
        idle(1);

        // Asynchronous reset during DRAIN after 4 outputs.
        make_seq(40, m);
        fill_matrix(m, 0);
        drain_n(4);
        reset = 1'b0;
        #1;
        check("reset_mid_drain", {29'd0, in_ready, out_valid, done}, 32'd4);
        @(posedge clk); #1;
        reset = 1'b1;
        make_seq(0, m);
        fill_matrix(m, 20);
        drain(30, cyc);
        n_mtx++;
        idle(2);

        @(negedge clk); #1;
        check("done_count", done_cnt, n_mtx);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
